// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - address map defaults, region type and decode helpers for mem_map_ctrl
package mem_map_pkg;

  localparam logic [31:0] DEF_RAM_BASE    = 32'h0000_0100;
  localparam logic [31:0] DEF_SW_BASE     = 32'h0000_0204;
  localparam logic [31:0] DEF_STICKY_ADDR = 32'h0000_0280;
  localparam int unsigned SW_STRIDE       = 4;

  typedef enum logic [2:0] {
    REG_ROM,
    REG_RAM,
    REG_SW,
    REG_STICKY,
    REG_NONE
  } region_t;

  // Regions that reject writes and report them on err.
  function automatic logic wr_is_illegal(input region_t r);
    return (r == REG_ROM) || (r == REG_SW) || (r == REG_NONE);
  endfunction

endpackage

// File: rtl/sw_sync.sv
// rtl/sw_sync.sv - one switch channel: 2-flop synchronizer plus rising-edge detect
module sw_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_async,
  output logic level,
  output logic rise
);

  logic s1;
  logic s2;
  logic prev;
  logic [1:0] age;

  // Two-stage synchronizer for the raw switch input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sw_async;
      s2 <= s1;
    end
  end

  // Edge reference tracks the synchronizer; edges are trusted only once the
  // reference holds a synchronized value, so a switch already high at reset
  // release does not look like a fresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
      age  <= 2'd0;
    end else begin
      prev <= s2;
      if (age != 2'd3) age <= age + 2'd1;
    end
  end

  assign level = s2;
  assign rise  = (age == 2'd3) && s2 && !prev;

endmodule

// File: rtl/mem_map_ctrl.sv
// rtl/mem_map_ctrl.sv - byte-addressed ROM/RAM/switch map controller; define MEM_MAP_STICKY_EN for sticky edge flags
module mem_map_ctrl
  import mem_map_pkg::*;
#(
  parameter int unsigned ROM_WORDS   = 256,
  parameter int unsigned RAM_WORDS   = 256,
  parameter int unsigned N_SW        = 7,
  parameter logic [31:0] RAM_BASE    = DEF_RAM_BASE,
  parameter logic [31:0] SW_BASE     = DEF_SW_BASE,
  parameter logic [31:0] STICKY_ADDR = DEF_STICKY_ADDR
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_SW-1:0]           sw,
  input  logic [31:0]               address,
  input  logic [31:0]               wdata,
  input  logic                      rd_en,
  input  logic                      wr_en,
  output logic [31:0]               rdata,
  output logic                      rvalid,
  output logic                      err,
  output logic [31:0]               rom_addr,
  input  logic [7:0]                rom_data,
  output logic [RAM_WORDS-1:0][7:0] char_data
);

  localparam int RAM_AW = $clog2(RAM_WORDS);

  region_t                    region;
  logic                       sw_bit;
  logic                       sw_hit;
  logic [N_SW-1:0]            sw_level;
  logic [N_SW-1:0]            sw_rise;
  logic [N_SW-1:0]            sticky_rd;
  logic [RAM_AW-1:0]          ram_idx;
  logic [RAM_WORDS-1:0][7:0]  ram;
  logic [31:0]                rd_word;
  logic                       unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  genvar g;
  generate
    for (g = 0; g < N_SW; g++) begin : g_sw
      sw_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_async (sw[g]),
        .level    (sw_level[g]),
        .rise     (sw_rise[g])
      );
    end
  endgenerate

  // Address decode; the switch lookup also picks out the addressed level.
  always_comb begin
    region = REG_NONE;
    sw_bit = 1'b0;
    sw_hit = 1'b0;
    for (int unsigned i = 0; i < N_SW; i++) begin
      if (address == SW_BASE + 32'(i) * SW_STRIDE) begin
        sw_hit = 1'b1;
        sw_bit = sw_level[i];
      end
    end
    if (address < ROM_WORDS) region = REG_ROM;
    else if (address >= RAM_BASE && address < RAM_BASE + RAM_WORDS) region = REG_RAM;
    else if (sw_hit) region = REG_SW;
    else if (address == STICKY_ADDR) region = REG_STICKY;
  end

  assign rom_addr  = (region == REG_ROM) ? address : 32'd0;
  assign ram_idx   = RAM_AW'(address - RAM_BASE);
  assign char_data = ram;

`ifdef MEM_MAP_STICKY_EN
  logic [N_SW-1:0] sticky;
  logic [N_SW-1:0] sticky_clr;

  assign sticky_clr = (wr_en && region == REG_STICKY) ? wdata[N_SW-1:0] : '0;

  // Sticky flags: a synchronized rising edge sets, write-one clears, set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky <= '0;
    else        sticky <= (sticky & ~sticky_clr) | sw_rise;
  end

  assign sticky_rd = sticky;
`else
  logic unused_rise;
  assign unused_rise = ^sw_rise;
  assign sticky_rd   = '0;
`endif

  // Read mux; RAM is read before this cycle's write lands.
  always_comb begin
    rd_word = '0;
    case (region)
      REG_ROM:    rd_word = 32'(rom_data);
      REG_RAM:    rd_word = 32'(ram[ram_idx]);
      REG_SW:     rd_word = 32'(sw_bit);
      REG_STICKY: rd_word = 32'(sticky_rd);
      default:    rd_word = '0;
    endcase
  end

  // Byte RAM, cleared by reset, written only inside its own region.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ram <= '0;
    else if (wr_en && region == REG_RAM) ram[ram_idx] <= wdata[7:0];
  end

  // Registered response: one-cycle read latency and the error strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      rvalid <= rd_en;
      rdata  <= rd_en ? rd_word : 32'd0;
      err    <= (rd_en && region == REG_NONE) || (wr_en && wr_is_illegal(region));
    end
  end

endmodule

// File: tb/tb_mem_map_ctrl.sv
// tb/tb_mem_map_ctrl.sv - scoreboard bench for mem_map_ctrl with directed and randomized traffic
module tb_mem_map_ctrl;

  localparam int N_SW      = 7;
  localparam int RAM_WORDS = 256;
`ifdef MEM_MAP_STICKY_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [N_SW-1:0]           sw;
  logic [31:0]               address;
  logic [31:0]               wdata;
  logic                      rd_en;
  logic                      wr_en;
  logic [31:0]               rdata;
  logic                      rvalid;
  logic                      err;
  logic [31:0]               rom_addr;
  logic [7:0]                rom_data;
  logic [RAM_WORDS-1:0][7:0] char_data;

  mem_map_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .address   (address),
    .wdata     (wdata),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .err       (err),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .char_data (char_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] rom_img [256];
  assign rom_data = rom_img[rom_addr[7:0]];

  typedef struct {
    int          cyc;
    logic        v;
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic [RAM_WORDS-1:0][7:0] model_ram;
  logic [N_SW-1:0]           model_sticky;
  logic [N_SW-1:0]           sw_drive;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // 0 ROM, 1 RAM, 2 switch, 3 sticky, 4 unmapped
  function automatic int region_of(input logic [31:0] a, output int idx);
    idx = 0;
    if (a < 32'h100) return 0;
    if (a >= 32'h100 && a < 32'h200) return 1;
    if (a >= 32'h204 && a < 32'h204 + 4 * N_SW && ((a - 32'h204) % 4) == 0) begin
      idx = int'((a - 32'h204) / 4);
      return 2;
    end
    if (a == 32'h280) return 3;
    return 4;
  endfunction

  function automatic logic [31:0] model_read(input int r, input int idx, input logic [31:0] a);
    case (r)
      0: return {24'd0, rom_img[a[7:0]]};
      1: return {24'd0, model_ram[a - 32'h100]};
      2: return {31'd0, sw_drive[idx]};
      3: return STICKY_EN ? {25'd0, model_sticky} : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic do_op(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    int   r;
    int   idx;
    exp_t e;
    @(posedge clk);
    #1;
    n_checks++;
    if (char_data !== model_ram) begin
      n_fail++;
      for (int i = 0; i < RAM_WORDS; i++) begin
        if (char_data[i] !== model_ram[i]) begin
          $display("FAIL char_data[%0d]: got %h, required %h (cycle %0d)", i, char_data[i], model_ram[i], cyc);
          break;
        end
      end
    end
    sw      = sw_drive;
    address = a;
    wdata   = wd;
    rd_en   = rd;
    wr_en   = wr;
    r = region_of(a, idx);
    e.cyc = cyc + 1;
    e.v   = rd;
    e.d   = rd ? model_read(r, idx, a) : 32'd0;
    e.e   = (rd && r == 4) || (wr && (r == 0 || r == 2 || r == 4));
    if (rd || e.e) exp_q.push_back(e);
    if (wr && r == 1) model_ram[a - 32'h100] = wd[7:0];
    if (wr && r == 3) model_sticky = model_sticky & ~wd[N_SW-1:0];
    #1;
    check("rom_addr", rom_addr, (r == 0) ? a : 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) do_op(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic set_sw(input logic [N_SW-1:0] v);
    model_sticky = model_sticky | (v & ~sw_drive);
    sw_drive = v;
    idle(5);
  endtask

  task automatic reset_mid_read(input logic [31:0] a);
    do_op(1'b1, 1'b0, a, 32'd0);
    #2;
    rst_n = 1'b0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    exp_q.delete();
    model_ram    = '0;
    model_sticky = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(5);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0: return 32'($urandom_range(0, 255));
      1: return 32'h100 + 32'($urandom_range(0, 255));
      2: return 32'h204 + 4 * 32'($urandom_range(0, 7));
      3: return 32'h280;
      4: return 32'h200 + 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  // Monitor: pops one expectation per presented response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_rvalid", {31'd0, rvalid}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
      end else if (rvalid || err) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got rvalid=%0b err=%0b rdata=%h, required no output (cycle %0d)", rvalid, err, rdata, cyc);
        end else begin
          e = exp_q.pop_front();
          check("resp_cycle", cyc, e.cyc);
          check("rvalid", {31'd0, rvalid}, {31'd0, e.v});
          check("err", {31'd0, err}, {31'd0, e.e});
          check("rdata", rdata, e.d);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missing_output: got no rvalid/err, required rvalid=%0b err=%0b rdata=%h (cycle %0d)", e.v, e.e, e.d, e.cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom_img[i] = 8'($urandom);
    rom_img[16]  = 8'hC3;
    rst_n        = 1'b0;
    sw           = '0;
    sw_drive     = '0;
    address      = '0;
    wdata        = '0;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    model_ram    = '0;
    model_sticky = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(5);

    // RAM write then read, live contents visible
    do_op(1'b0, 1'b1, 32'h105, 32'h5A);
    do_op(1'b1, 1'b0, 32'h105, 32'd0);
    idle(1);
    check("char_data_5", {24'd0, char_data[5]}, 32'h5A);

    // ROM read through external ROM
    do_op(1'b1, 1'b0, 32'h010, 32'd0);
    do_op(1'b1, 1'b0, 32'h0FF, 32'd0);

    // Switch 2 level, sticky set and clear
    set_sw(7'b0000100);
    do_op(1'b1, 1'b0, 32'h20C, 32'd0);
    do_op(1'b1, 1'b0, 32'h280, 32'd0);
    do_op(1'b0, 1'b1, 32'h280, 32'h4);
    do_op(1'b1, 1'b0, 32'h280, 32'd0);

    // Illegal write and unmapped read; RAM untouched
    do_op(1'b0, 1'b1, 32'h020, 32'hFF);
    do_op(1'b1, 1'b0, 32'h300, 32'd0);
    do_op(1'b0, 1'b1, 32'h204, 32'h1);
    do_op(1'b1, 1'b0, 32'h200, 32'd0);
    do_op(1'b1, 1'b0, 32'h220, 32'd0);
    do_op(1'b1, 1'b0, 32'h205, 32'd0);
    do_op(1'b1, 1'b0, 32'h218, 32'd0);

    // Read-before-write at the top RAM byte
    do_op(1'b0, 1'b1, 32'h1FF, 32'h11);
    do_op(1'b1, 1'b1, 32'h1FF, 32'h22);
    do_op(1'b1, 1'b0, 32'h1FF, 32'd0);

    // Edge of sw[3] arriving together with a clear of the same bit
    sw_drive = sw_drive | 7'b0001000;
    idle(2);
    do_op(1'b0, 1'b1, 32'h280, 32'h8);
    model_sticky = model_sticky | 7'b0001000;
    idle(3);
    do_op(1'b1, 1'b0, 32'h280, 32'd0);

    // Reset during a read with sw[0] held high
    set_sw(7'b0000001);
    reset_mid_read(32'h280);
    do_op(1'b1, 1'b0, 32'h280, 32'd0);
    do_op(1'b1, 1'b0, 32'h204, 32'd0);
    do_op(1'b1, 1'b0, 32'h105, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 29) == 0) set_sw(N_SW'($urandom));
      else do_op(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), rand_addr(), $urandom);
    end

    idle(3);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outstanding responses, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
